// File: rtl/tick_pkg.sv
// Shared types and constants for the tick scheduler and its round-robin arbiter.
package tick_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int DIV_DEFAULT   = 2200;
    localparam int MISS_W        = 8;
    localparam int MAX_REQ       = 8;
    localparam int PTR_W         = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the set bit of a one-hot vector; zero when nothing is set.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr+1, wrapping.
module rr_arbiter
    import tick_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] sel,
    output logic             valid
);

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        // Walk offsets 1..N_REQ from the pointer so the last winner has lowest priority.
        for (int off = 1; off <= N_REQ; off++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid && req[j] && (j == ((int'(ptr) + off) % N_REQ))) begin
                    sel[j] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable slow-tick generator that shares each tick slot among N_REQ consumers
// through a round-robin grant/done handshake, with overrun tracking and live re-divide.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT,
    parameter int N_REQ       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  grant,
    output logic              tick,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [MISS_W-1:0] miss_cnt,
    output state_t            state
);

    // cfg handshake: a transfer happens on any cycle where cfg_valid && cfg_ready;
    // cfg_ready stays low from capture until the cycle after the value reaches div_q.

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_pend;
    logic             pend;
    logic             applied;
    logic             tick_hit;
    logic             apply_now;

    assign tick_hit  = en && (cnt == div_q);
    assign apply_now = pend && !applied && (tick_hit || !en);
    assign cfg_ready = !pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= tick_hit;
            if (!en || tick_hit) cnt <= '0;
            else                 cnt <= cnt + CNT_W'(1);
        end
    end

    // A new divide only lands on a period boundary so the running period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= CNT_W'(DEFAULT_DIV);
            div_pend <= '0;
            pend     <= 1'b0;
            applied  <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                div_pend <= cfg_div;
                pend     <= 1'b1;
            end
            if (apply_now) begin
                div_q   <= div_pend;
                applied <= 1'b1;
            end
            if (applied) begin
                pend    <= 1'b0;
                applied <= 1'b0;
            end
        end
    end

    logic [N_REQ-1:0] arb_sel;
    logic             arb_valid;
    logic [PTR_W-1:0] ptr;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    state_t           state_d;
    logic [N_REQ-1:0] grant_d;
    logic             busy_d;
    logic [PTR_W-1:0] ptr_d;
    logic             miss_evt;
    logic             done_hit;

    assign done_hit = |(done & grant);

    always_comb begin
        state_d  = state;
        grant_d  = grant;
        busy_d   = busy;
        ptr_d    = ptr;
        miss_evt = 1'b0;
        case (state)
            IDLE: begin
                if (tick && arb_valid) begin
                    grant_d = arb_sel;
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A tick that lands with done is consumed by the release, not counted as lost.
                if (done_hit) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = onehot_to_idx(MAX_REQ'(grant));
                    state_d = IDLE;
                end else if (tick) begin
                    miss_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= PTR_W'(N_REQ - 1);
        end else begin
            state <= state_d;
            grant <= grant_d;
            busy  <= busy_d;
            ptr   <= ptr_d;
        end
    end

    // Set has priority over clear so a miss in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            miss_cnt <= '0;
        end else if (miss_evt) begin
            overrun <= 1'b1;
            if (ovr_clr)              miss_cnt <= MISS_W'(1);
            else if (miss_cnt != '1)  miss_cnt <= miss_cnt + MISS_W'(1);
        end else if (ovr_clr) begin
            overrun  <= 1'b0;
            miss_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a short default divide so every period is hand-countable.
module tb_tick_scheduler;
    import tick_pkg::*;

    localparam int CNT_W   = 16;
    localparam int N_REQ   = 4;
    localparam int DEF_DIV = 3;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              en        = 1'b0;
    logic [CNT_W-1:0]  cfg_div   = '0;
    logic              cfg_valid = 1'b0;
    logic              ovr_clr   = 1'b0;
    logic [N_REQ-1:0]  req       = '0;
    logic [N_REQ-1:0]  done      = '0;
    logic              cfg_ready;
    logic [N_REQ-1:0]  grant;
    logic              tick;
    logic              busy;
    logic              overrun;
    logic [MISS_W-1:0] miss_cnt;
    state_t            state;

    int total = 0;
    int bad   = 0;
    int n;
    logic [N_REQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    tick_scheduler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .N_REQ       (N_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .tick      (tick),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .miss_cnt  (miss_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of edges until tick is seen; 21 means it never came.
    task automatic wait_tick(output int cycles);
        cycles = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (tick) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) step();
        check("rst_tick", 32'(tick), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_miss", 32'(miss_cnt), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;
        step();

        en = 1'b1;
        wait_tick(n);
        check("first_tick_latency", 32'(n), 4);
        wait_tick(n);
        check("tick_period", 32'(n), 4);
        check("no_grant_without_req", 32'(grant), 0);

        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                wait_tick(n);
                check("rr_tick_gap", 32'(n), 1);
            end
            step();
            check("rr_grant", 32'(grant), 32'(rr_exp[i]));
            check("rr_busy", 32'(busy), 1);
            step();
            done = rr_exp[i];
            step();
            done = '0;
            check("rr_release", 32'(grant), 0);
        end
        req = '0;

        wait_tick(n);
        check("pre_cfg_tick", 32'(n), 1);
        step();
        cfg_div   = 16'd1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("cfg_ready_drop", 32'(cfg_ready), 0);
        wait_tick(n);
        check("cfg_period_kept", 32'(n), 2);
        check("cfg_ready_apply_cycle", 32'(cfg_ready), 0);
        step();
        check("cfg_ready_back", 32'(cfg_ready), 1);
        check("cfg_no_tick", 32'(tick), 0);
        wait_tick(n);
        check("div1_first", 32'(n), 1);
        wait_tick(n);
        check("div1_period", 32'(n), 2);

        req = 4'b0100;
        step();
        check("ovr_grant", 32'(grant), 32'(4'b0100));
        check("ovr_state", 32'(state), 32'(GRANT));
        req  = '0;
        done = 4'b1011;
        step();
        done = '0;
        check("ovr_grant_held", 32'(grant), 32'(4'b0100));
        check("ovr_tick_align", 32'(tick), 1);
        step();
        check("ovr_miss1", 32'(miss_cnt), 1);
        for (int i = 2; i <= 3; i++) begin
            wait_tick(n);
            step();
            check("ovr_miss_n", 32'(miss_cnt), 32'(i));
        end
        check("ovr_sticky", 32'(overrun), 1);
        check("ovr_grant_still", 32'(grant), 32'(4'b0100));
        check("ovr_busy", 32'(busy), 1);

        ovr_clr = 1'b1;
        step();
        check("clr_tick_align", 32'(tick), 1);
        check("clr_overrun", 32'(overrun), 0);
        check("clr_miss", 32'(miss_cnt), 0);
        step();
        ovr_clr = 1'b0;
        check("clr_set_wins_ovr", 32'(overrun), 1);
        check("clr_set_wins_miss", 32'(miss_cnt), 1);

        step();
        check("coinc_tick_align", 32'(tick), 1);
        done = 4'b0100;
        req  = 4'b0001;
        step();
        done = '0;
        check("coinc_release", 32'(grant), 0);
        check("coinc_busy", 32'(busy), 0);
        check("coinc_no_miss", 32'(miss_cnt), 1);
        check("coinc_state", 32'(state), 32'(IDLE));
        step();
        check("coinc_next_tick", 32'(tick), 1);
        check("coinc_no_grant", 32'(grant), 0);
        step();
        check("coinc_next_grant", 32'(grant), 32'(4'b0001));

        cfg_div   = 16'd5;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        req       = '0;
        check("rst_pend_ready", 32'(cfg_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 0);
        check("async_busy", 32'(busy), 0);
        check("async_cfg_ready", 32'(cfg_ready), 1);
        check("async_overrun", 32'(overrun), 0);
        check("async_miss", 32'(miss_cnt), 0);
        check("async_tick", 32'(tick), 0);
        #1;
        rst_n = 1'b1;
        wait_tick(n);
        check("rst_div_default", 32'(n), 4);
        check("rst_no_grant", 32'(grant), 0);

        en        = 1'b0;
        cfg_div   = 16'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("en0_capture", 32'(cfg_ready), 0);
        step();
        check("en0_apply", 32'(cfg_ready), 0);
        check("en0_no_tick", 32'(tick), 0);
        step();
        check("en0_ready_back", 32'(cfg_ready), 1);
        check("en0_still_no_tick", 32'(tick), 0);
        en = 1'b1;
        wait_tick(n);
        check("div2_first", 32'(n), 3);
        wait_tick(n);
        check("div2_period", 32'(n), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
